// File: rtl/seq_mult_if.sv
// Operand/product handshake bundle for the sequential multiplier.
interface seq_mult_if #(
  parameter int WIDTH = 32
);
  logic                 in_valid;
  logic                 in_ready;
  logic                 in_signed;
  logic [WIDTH-1:0]     a;
  logic [WIDTH-1:0]     b;
  logic                 out_valid;
  logic                 out_ready;
  logic [2*WIDTH-1:0]   product;
  logic                 busy;

  modport slave (
    input  in_valid, in_signed, a, b, out_ready,
    output in_ready, out_valid, product, busy
  );

  modport master (
    output in_valid, in_signed, a, b, out_ready,
    input  in_ready, out_valid, product, busy
  );
endinterface

// File: rtl/seq_mult.sv
// Iterative shift-add multiplier: sign-magnitude core, one partial product per clock,
// fixed WIDTH+2 cycle latency from accept to out_valid.
module seq_mult #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic       clk,
  input  logic       rst_n,
  seq_mult_if.slave  bus
);

  localparam int PW = 2 * WIDTH;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_e;

  state_e             state_q;
  logic [PW:0]        acc_q;
  logic [WIDTH-1:0]   mcand_q;
  logic [WIDTH-1:0]   mplier_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               neg_q;
  logic [PW-1:0]      product_q;
  logic               out_valid_q;

  logic               sign_a_d;
  logic               sign_b_d;
  logic [WIDTH-1:0]   mag_a_d;
  logic [WIDTH-1:0]   mag_b_d;
  logic [WIDTH:0]     sum_d;
  logic [PW:0]        acc_d;
  logic [PW-1:0]      fix_d;

  // Operand magnitudes, one shift-add step, and the final sign fix-up.
  always_comb begin
    sign_a_d = bus.in_signed & bus.a[WIDTH-1];
    sign_b_d = bus.in_signed & bus.b[WIDTH-1];
    // -2^(WIDTH-1) negates to itself, which is the correct unsigned magnitude
    mag_a_d  = sign_a_d ? (~bus.a + WIDTH'(1)) : bus.a;
    mag_b_d  = sign_b_d ? (~bus.b + WIDTH'(1)) : bus.b;
    sum_d    = {acc_q[PW], acc_q[PW-1:WIDTH]}
             + {1'b0, (mplier_q[0] ? mcand_q : {WIDTH{1'b0}})};
    acc_d    = {sum_d, acc_q[WIDTH-1:0]} >> 1;
    fix_d    = neg_q ? (~acc_q[PW-1:0] + PW'(1)) : acc_q[PW-1:0];
  end

  // Control FSM and datapath registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      acc_q       <= {(PW+1){1'b0}};
      mcand_q     <= {WIDTH{1'b0}};
      mplier_q    <= {WIDTH{1'b0}};
      cnt_q       <= {CNT_W{1'b0}};
      neg_q       <= 1'b0;
      product_q   <= {PW{1'b0}};
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.in_valid) begin
            neg_q    <= sign_a_d ^ sign_b_d;
            mcand_q  <= mag_a_d;
            mplier_q <= mag_b_d;
            acc_q    <= {(PW+1){1'b0}};
            cnt_q    <= CNT_W'(WIDTH);
            state_q  <= CALC;
          end
        end
        CALC: begin
          acc_q    <= acc_d;
          mplier_q <= mplier_q >> 1;
          cnt_q    <= cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            state_q <= FIX;
          end
        end
        FIX: begin
          product_q <= fix_d;
          state_q   <= DONE;
        end
        DONE: begin
          // first DONE cycle raises out_valid; product is already stable
          if (!out_valid_q) begin
            out_valid_q <= 1'b1;
          end else if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: begin
          state_q     <= IDLE;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.busy      = (state_q == CALC) || (state_q == FIX);
  assign bus.out_valid = out_valid_q;
  assign bus.product   = product_q;

endmodule

// File: tb/tb_seq_mult.sv
// Directed and randomized check of seq_mult (WIDTH=32) against an arithmetic reference.
module tb_seq_mult;

  localparam int W = 32;

  logic clk = 1'b0;
  logic rst_n;
  int   vectors = 0;
  int   miscompares = 0;

  seq_mult_if #(.WIDTH(W)) bus();

  seq_mult #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check64(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] ref_mul(input logic s, input logic [31:0] x, input logic [31:0] y);
    longint      sx, sy;
    logic [63:0] ux, uy;
    sx = $signed(x);
    sy = $signed(y);
    ux = {32'd0, x};
    uy = {32'd0, y};
    if (s) return 64'(sx * sy);
    else   return ux * uy;
  endfunction

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 7))
      0:       return 32'h0000_0000;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h0000_0001;
      default: return $urandom;
    endcase
  endfunction

  // One full operation: accept, latency, result, optional backpressure, handshake.
  task automatic do_op(input logic s, input logic [31:0] x, input logic [31:0] y,
                       input logic [63:0] exp, input int hold, input string tag);
    int lat;
    int guard;
    guard = 0;
    @(negedge clk);
    while (!bus.in_ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    check64({tag, " idle_ready"}, 64'(bus.in_ready), 64'd1);
    bus.in_valid  = 1'b1;
    bus.in_signed = s;
    bus.a         = x;
    bus.b         = y;
    bus.out_ready = 1'($urandom_range(0, 1));
    @(posedge clk);
    #1;
    bus.in_valid  = 1'b0;
    bus.a         = $urandom;
    bus.b         = $urandom;
    bus.in_signed = 1'($urandom_range(0, 1));
    lat = 0;
    while (lat < 200) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (bus.out_valid) break;
      bus.out_ready = 1'($urandom_range(0, 1));
    end
    check64({tag, " latency"}, 64'(lat), 64'd34);
    check64({tag, " product"}, bus.product, exp);
    for (int i = 0; i < hold; i++) begin
      bus.out_ready = 1'b0;
      bus.in_valid  = 1'b1;
      bus.a         = $urandom;
      bus.b         = $urandom;
      @(posedge clk);
      @(negedge clk);
      check64({tag, " held_product"}, bus.product, exp);
      check64({tag, " held_valid"}, 64'(bus.out_valid), 64'd1);
      check64({tag, " held_in_ready"}, 64'(bus.in_ready), 64'd0);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check64({tag, " post_valid"}, 64'(bus.out_valid), 64'd0);
    check64({tag, " post_in_ready"}, 64'(bus.in_ready), 64'd1);
    check64({tag, " post_busy"}, 64'(bus.busy), 64'd0);
    bus.out_ready = 1'b0;
  endtask

  initial begin
    logic        s;
    logic [31:0] x, y;
    logic        seen;

    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_signed = 1'b0;
    bus.a         = 32'd0;
    bus.b         = 32'd0;
    bus.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check64("reset in_ready", 64'(bus.in_ready), 64'd1);
    check64("reset out_valid", 64'(bus.out_valid), 64'd0);
    check64("reset busy", 64'(bus.busy), 64'd0);
    check64("reset product", bus.product, 64'd0);

    do_op(1'b1, 32'hFFFF_FFFD, 32'd7, 64'hFFFF_FFFF_FFFF_FFEB, 0, "signed_basic");
    do_op(1'b1, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000, 0, "signed_min_sq");
    do_op(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 0, "unsigned_max_sq");
    do_op(1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'd1, 0, "signed_m1_sq");
    do_op(1'b1, 32'd0, 32'h8000_0000, 64'd0, 0, "signed_zero");
    do_op(1'b0, 32'd6, 32'd7, 64'd42, 5, "backpressure");

    // Abort an operation part-way through CALC.
    @(negedge clk);
    bus.in_valid  = 1'b1;
    bus.in_signed = 1'b0;
    bus.a         = 32'd5;
    bus.b         = 32'd5;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    check64("midrst busy_before", 64'(bus.busy), 64'd1);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    check64("midrst busy", 64'(bus.busy), 64'd0);
    check64("midrst in_ready", 64'(bus.in_ready), 64'd1);
    check64("midrst product", bus.product, 64'd0);
    seen = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (bus.out_valid) seen = 1'b1;
    end
    check64("midrst no_output", 64'(seen), 64'd0);
    do_op(1'b1, 32'd2, 32'hFFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFC, 0, "after_reset");

    for (int n = 0; n < 1000; n++) begin
      s = 1'($urandom_range(0, 1));
      x = pick_operand();
      y = pick_operand();
      do_op(s, x, y, ref_mul(s, x, y), $urandom_range(0, 3), "random");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/seq_mult.md
Name: seq_mult

Overview:
- Parametrised, multi-cycle, iterative integer multiplier. Successor to the single-cycle behavioural product.
- Computes a full-width product of two WIDTH-bit operands, interpreted as either signed (two's complement) or unsigned, selectable per operation.
- Uses one shift-add step per clock, behind valid/ready handshakes on input and output.
- Sits in datapaths where a combinational WIDTHxWIDTH multiplier is too large or too slow. The formal bench checks product == a*b under the selected interpretation.

Parameters:
- WIDTH, 32, operand width in bits (legal range 2..64); product is 2*WIDTH bits
- CNT_W, $clog2(WIDTH+1), iteration counter width (derived; do not override)

Ports:
- clk  input  1  single clock; all state updates on rising edge
- rst_n  input  1  synchronous, active-low reset
- in_valid  input  1  operands and mode are presented
- in_ready  output  1  block can accept an operation
- in_signed  input  1  1 = a and b are two's complement; 0 = unsigned
- a  input  WIDTH  multiplicand
- b  input  WIDTH  multiplier
- out_valid  output  1  product is available
- out_ready  input  1  consumer accepts the product
- product  output  2*WIDTH  result, signed or unsigned per captured in_signed
- busy  output  1  high in CALC or FIX state

Behaviour:
- Reset: when rst_n==0 at a rising edge:
  - state=IDLE
  - in_ready=1 (comb from state), out_valid=0, busy=0
  - product=0, counter=0, internal accumulators=0
- Reset applied mid-CALC/FIX/DONE aborts the operation; no product is emitted.
- FSM states: IDLE, CALC, FIX, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready, capture in_signed, the sign of a and the sign of b (MSB if in_signed, else 0), and |a|, |b| as WIDTH-bit unsigned magnitudes.
  - -2^(WIDTH-1) has magnitude 2^(WIDTH-1); this is representable unsigned.
  - Clear the accumulator, load counter=WIDTH, go to CALC.
- CALC:
  - Each cycle: if the multiplier LSB==1, add the multiplicand magnitude into the upper half of the 2*WIDTH+1-bit accumulator; shift right 1; shift the multiplier right 1; decrement the counter.
  - When the counter reaches 1 in CALC, go to FIX next edge. CALC lasts exactly WIDTH cycles.
- FIX (1 cycle): product = negate(accumulator) if sign_a XOR sign_b, else the accumulator. Go to DONE with out_valid=1.
- Latency: out_valid rises exactly WIDTH+2 rising edges after the accepting edge (WIDTH CALC + 1 FIX + 1 registered output). Latency is fixed and independent of operand values.
- DONE:
  - out_valid=1; product is held stable while out_valid&&!out_ready.
  - On out_valid&&out_ready: out_valid=0, state=IDLE, in_ready=1 in the following cycle.
  - product keeps its last value after the handshake; it is don't-care when out_valid==0.
- No overlap: in_ready=0 in CALC, FIX and DONE. in_valid asserted there is ignored and must be held by the producer.
- Operand inputs are sampled only at the accepting edge; later changes have no effect.
- Arithmetic rules:
  - Result is exact in 2*WIDTH bits for all inputs.
  - Signed extreme: (-2^(W-1))^2 = 2^(2W-2), no overflow.
  - Unsigned extreme: (2^W-1)^2 = 2^(2W) - 2^(W+1) + 1.
  - Zero operand gives product 0 for either sign.
  - Negating 0 yields 0.
- out_ready high in any other state has no effect.

Test Plan (WIDTH=32):
- Reset then idle: rst_n low 2 cycles, release -> in_ready=1, out_valid=0, busy=0, product=0.
- Signed basic: in_signed=1, a=-3 (0xFFFFFFFD), b=7, out_ready=1 -> out_valid exactly 34 edges after accept, product=0xFFFFFFFFFFFFFFEB (-21), one-cycle pulse, then in_ready=1.
- Extremes:
  - Signed a=b=0x80000000 -> product=0x4000000000000000.
  - Unsigned a=b=0xFFFFFFFF -> product=0xFFFFFFFE00000001.
  - Signed same operands (a=b=0xFFFFFFFF) -> product=1.
- Backpressure: a=6, b=7 unsigned, out_ready=0 for 5 cycles after out_valid -> product=42 held stable, in_ready=0, a new in_valid is ignored. out_ready=1 -> handshake completes, IDLE.
- Reset mid-operation: accept a=5, b=5, assert rst_n=0 at cycle 10 of CALC -> next edge state IDLE, out_valid never rises. Next op a=2, b=-2 signed -> product=-4.
- Back-to-back with random operands: 1000 ops, random in_signed, random out_ready -> each product equals the reference a*b model, and latency is always 34.
